// File: rtl/polytris_led_sequencer.sv
// LED bank sequencer: static/blink/chase patterns plus hw/sw flash.
// Ports: clk, reset, Avalon-MM slave (address, chipselect, write_n,
// writedata, readdata), flash_req in, led_out and busy out.
module polytris_led_sequencer #(
  parameter int WIDTH       = 14,
  parameter int PERIOD_W    = 24,
  parameter int FLASH_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             flash_req,
  output logic [WIDTH-1:0] led_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE, RUN, FLASH_ON, FLASH_OFF
  } state_t;

  state_t              state, state_n;
  logic                en, en_n;
  logic [1:0]          mode, mode_n;
  logic [WIDTH-1:0]    pattern, pattern_n;
  logic [WIDTH-1:0]    rot, rot_n;
  logic [PERIOD_W-1:0] period, period_n;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic [PERIOD_W-1:0] plim;
  logic [3:0]          remaining, remaining_n;
  logic                phase, phase_n;
  logic                tick, wr, flashing;
  logic                wr_ctrl, wr_pat, wr_per, sw_flash, trig;

  assign wr       = chipselect && !write_n;
  assign wr_ctrl  = wr && (address == 2'd0);
  assign wr_pat   = wr && (address == 2'd1);
  assign wr_per   = wr && (address == 2'd2);
  assign sw_flash = wr && (address == 2'd3)
                 && (writedata[3:0] != 4'd0);
  assign trig     = flash_req || sw_flash;
  assign flashing = (state == FLASH_ON) || (state == FLASH_OFF);
  assign busy     = flashing;

  assign plim = (period == '0) ? PERIOD_W'(1) : period;
  // >= so a PERIOD shrunk mid-count still wraps promptly
  assign tick = (cnt >= plim - PERIOD_W'(1));

  always_comb begin
    readdata = 32'd0;
    unique case (address)
      2'd0: readdata = {29'd0, mode, en};
      2'd1: readdata = 32'(pattern);
      2'd2: readdata = 32'(period);
      2'd3: readdata = {27'd0, busy, remaining};
      default: readdata = 32'd0;
    endcase
  end

  always_comb begin
    led_out = '0;
    unique case (state)
      RUN: begin
        unique case (mode)
          2'd0: led_out = pattern;
          2'd1: led_out = phase ? '0 : pattern;
          default: led_out = rot;
        endcase
      end
      FLASH_ON: led_out = '1;
      default: led_out = '0;
    endcase
  end

  always_comb begin
    state_n     = state;
    en_n        = en;
    mode_n      = mode;
    pattern_n   = pattern;
    period_n    = period;
    rot_n       = rot;
    phase_n     = phase;
    remaining_n = remaining;
    cnt_n       = tick ? '0 : cnt + PERIOD_W'(1);

    if (wr_ctrl) begin
      en_n   = writedata[0];
      mode_n = writedata[2:1];
    end
    if (wr_pat) pattern_n = writedata[WIDTH-1:0];
    if (wr_per) period_n = writedata[PERIOD_W-1:0];
    if (!flashing && (wr_ctrl || wr_per)) cnt_n = '0;

    if (trig) begin
      state_n     = FLASH_ON;
      remaining_n = flash_req ? 4'(FLASH_COUNT) : writedata[3:0];
      cnt_n       = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_ctrl && writedata[0]) begin
            state_n = RUN;
            phase_n = 1'b0;
            rot_n   = pattern;
          end
        end
        RUN: begin
          if (wr_ctrl && !writedata[0]) begin
            state_n = IDLE;
          end else if (wr_ctrl || wr_pat) begin
            rot_n   = pattern_n;
            phase_n = 1'b0;
          end else if (tick) begin
            phase_n = !phase;
            if (mode == 2'd2) rot_n = {rot[WIDTH-2:0], rot[WIDTH-1]};
            if (mode == 2'd3) rot_n = {rot[0], rot[WIDTH-1:1]};
          end
        end
        FLASH_ON: begin
          if (tick) state_n = FLASH_OFF;
        end
        FLASH_OFF: begin
          if (tick) begin
            remaining_n = remaining - 4'd1;
            if (remaining_n == 4'd0) begin
              state_n = en ? RUN : IDLE;
              rot_n   = pattern;
              phase_n = 1'b0;
              cnt_n   = '0;
            end else begin
              state_n = FLASH_ON;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      en        <= 1'b0;
      mode      <= 2'd0;
      pattern   <= '0;
      period    <= '0;
      rot       <= '0;
      phase     <= 1'b0;
      remaining <= 4'd0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      en        <= en_n;
      mode      <= mode_n;
      pattern   <= pattern_n;
      period    <= period_n;
      rot       <= rot_n;
      phase     <= phase_n;
      remaining <= remaining_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_polytris_led_sequencer.sv
// Directed bench for polytris_led_sequencer with a per-cycle
// expected-output queue for led_out and busy.
module tb_polytris_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        flash_req;
  logic [13:0] led_out;
  logic        busy;

  typedef struct packed {
    logic [13:0] led;
    logic        bsy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  polytris_led_sequencer dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .flash_req(flash_req), .led_out(led_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic push(input logic [13:0] l, input logic b, input int n);
    exp_t e;
    e.led = l; e.bsy = b;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_led"}, 32'(led_out), 32'(e.led));
      chk({tag, "_busy"}, 32'(busy), 32'(e.bsy));
      if (exp_q.size() > 0) step();
    end
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; flash_req = 1'b0;
    step(); step();
    reset = 1'b0;
    push(14'h0, 1'b0, 2);
    drain("reset");
    rd("reset_ctrl", 2'd0, 32'd0);

    wr(2'd1, 32'h2A5A);
    wr(2'd0, 32'h1);
    push(14'h2A5A, 1'b0, 3);
    rd("static_rd_pat", 2'd1, 32'h0000_2A5A);
    drain("static");

    wr(2'd1, 32'h3FFF);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h3);
    push(14'h3FFF, 1'b0, 4);
    push(14'h0000, 1'b0, 4);
    push(14'h3FFF, 1'b0, 4);
    push(14'h0000, 1'b0, 1);
    rd("blink_rd_ctrl", 2'd0, 32'h3);
    drain("blink");

    wr(2'd1, 32'h2000);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h5);
    push(14'h2000, 1'b0, 1);
    push(14'h0001, 1'b0, 1);
    push(14'h0002, 1'b0, 1);
    drain("chase_l");

    wr(2'd2, 32'd0);
    wr(2'd1, 32'h0001);
    wr(2'd0, 32'h7);
    push(14'h0001, 1'b0, 1);
    push(14'h2000, 1'b0, 1);
    push(14'h1000, 1'b0, 1);
    drain("chase_r");

    wr(2'd2, 32'd2);
    wr(2'd1, 32'h00F0);
    wr(2'd0, 32'h1);
    chk("flash_pre", 32'(led_out), 32'h00F0);
    flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    rd("flash_rd_st", 2'd3, 32'h13);
    for (int i = 0; i < 3; i++) begin
      push(14'h3FFF, 1'b1, 2);
      push(14'h0000, 1'b1, 2);
    end
    push(14'h00F0, 1'b0, 2);
    drain("hwflash");

    flash_req = 1'b1;
    address = 2'd3; writedata = 32'd5;
    chipselect = 1'b1; write_n = 1'b0;
    step();
    flash_req = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    rd("conflict_rem", 2'd3, 32'h13);
    chk("conflict_led", 32'(led_out), 32'h3FFF);
    step(); step();
    chk("pre_retrig_led", 32'(led_out), 32'h0);
    wr(2'd3, 32'd2);
    rd("retrig_rem", 2'd3, 32'h12);
    for (int i = 0; i < 2; i++) begin
      push(14'h3FFF, 1'b1, 2);
      push(14'h0000, 1'b1, 2);
    end
    push(14'h00F0, 1'b0, 1);
    drain("retrig");

    flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    chk("midflash_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rd("rst_r0", 2'd0, 32'h0);
    rd("rst_r1", 2'd1, 32'h0);
    rd("rst_r2", 2'd2, 32'h0);
    rd("rst_r3", 2'd3, 32'h0);
    step();
    chk("rst_led2", 32'(led_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/polytris_led_sequencer.md
Name: polytris_led_sequencer

Overview:
- Avalon-MM slave sequencer that owns the 14-bit board LED bank and generates timed patterns in hardware: static, blink, chase-left and chase-right.
- Also arbitrates between the software-programmed pattern and a hardware "flash" request from game logic, for example on a line clear.
- Sits beside the HPS/Nios bus; its led_out drives the board LEDs in place of a plain PIO.

Parameters:
- WIDTH, 14, LED count / pattern width.
- PERIOD_W, 24, width of step-period register.
- FLASH_COUNT, 3, on/off flash pairs produced per hardware flash_req.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- flash_req  in  1  one-cycle hardware flash request.
- led_out  out  WIDTH  LED drive.
- busy  out  1  high while a flash sequence runs.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Write accepted on a rising clk edge when chipselect=1 and write_n=0.
- Register map:
  - Addr 0 CTRL: bit0 EN; bits2:1 MODE (0 static, 1 blink, 2 chase-left, 3 chase-right). Read returns {29'b0, MODE, EN}.
  - Addr 1 PATTERN [WIDTH-1:0]. Read zero-extended.
  - Addr 2 PERIOD [PERIOD_W-1:0], in clk cycles per step. Read zero-extended.
  - Addr 3 FLASH: a write with writedata[3:0]!=0 starts a software flash of writedata[3:0] pairs; a write of 0 is ignored. Read returns {27'b0, busy, remaining[3:0]}.
- Reset values: CTRL=0, PATTERN=0, PERIOD=0, remaining=0, busy=0, led_out=0, tick counter=0, phase=0, rotate reg=0.
- Tick generator:
  - Counter runs 0..P-1, where P = (PERIOD==0) ? 1 : PERIOD.
  - tick=1 in the cycle the counter equals P-1; the counter then wraps to 0.
  - Counter clears to 0 on any write to CTRL or PERIOD outside FLASH, and on every FLASH entry or exit.
- States: IDLE, RUN, FLASH_ON, FLASH_OFF.
- IDLE (EN=0):
  - led_out=0.
  - Moves to RUN on the edge that writes EN=1: phase=0, rotate reg=PATTERN.
- RUN:
  - Static: led_out=PATTERN.
  - Blink: led_out = phase ? 0 : PATTERN; phase toggles on each tick.
  - Chase-left: rotate reg rotates left 1 per tick (bit WIDTH-1 wraps to bit0).
  - Chase-right: rotate reg rotates right 1 per tick (bit0 wraps to bit WIDTH-1).
  - In both chase modes led_out = rotate reg.
  - A write to PATTERN or CTRL reloads rotate reg from PATTERN (new value) and clears phase.
  - A write of EN=0 moves to IDLE.
- Flash entry:
  - Triggered by flash_req=1, or by a FLASH write, from any state, regardless of EN.
  - remaining = FLASH_COUNT for flash_req, or writedata[3:0] for a software flash.
  - Goes to FLASH_ON with busy=1.
  - If both triggers occur in the same cycle, flash_req wins.
- FLASH_ON: led_out = all ones; on tick go to FLASH_OFF.
- FLASH_OFF:
  - led_out = 0.
  - On tick, decrement remaining. If the result is 0, exit; otherwise return to FLASH_ON.
- Flash exit: go to RUN if EN=1, else IDLE; rotate reg=PATTERN, phase=0, busy=0.
- Retrigger during FLASH reloads remaining and restarts at FLASH_ON with the counter cleared.
- CTRL, PATTERN and PERIOD writes during FLASH update the registers only.
  - They take effect at flash exit.
  - A new PERIOD applies immediately to the running counter compare.
  - The counter does not clear on these writes.
- Timing:
  - led_out, busy and remaining are driven only from registers; there is no combinational path from bus inputs or flash_req.
  - Effect is visible in the cycle after the accepting edge: one-cycle latency.
- Reset asserted mid-operation (including mid-flash) returns all state to the reset values on the next edge; a pending flash is discarded.

Test Plan:
- Static mode: reset, write PATTERN=0x2A5A, CTRL=0x1 -> led_out=0x2A5A the cycle after the CTRL write; readdata at addr1 = 0x00002A5A.
- Blink mode: PATTERN=0x3FFF, PERIOD=4, CTRL=0x3 -> led_out alternates 0x3FFF and 0x0000, each held exactly 4 cycles.
- Chase-left wrap: PATTERN=0x2000, PERIOD=1, CTRL=0x5 -> led_out goes 0x2000, 0x0001, 0x0002 on successive cycles.
- Chase-right with PERIOD=0: PATTERN=0x0001, CTRL=0x7 -> led_out goes 0x0001, 0x2000, 0x1000, stepping every cycle.
- Hardware flash, FLASH_COUNT=3, PERIOD=2, static PATTERN=0x00F0:
  - Pulse flash_req -> busy=1; 3 pairs of 0x3FFF for 2 cycles, 0 for 2 cycles.
  - Then led_out=0x00F0, busy=0.
  - Read addr3 mid-flash shows bit4=1.
- Conflicts and reset:
  - flash_req and a FLASH write (count 5) in the same cycle -> remaining=3.
  - Retrigger mid-flash restarts at FLASH_ON.
  - Reset asserted mid-flash -> next cycle led_out=0, busy=0, all registers read 0.
